write_addr_gen_c: RTL and testbench
===================================

WRITE_ADDR_GEN_C -- requirements
Module: write_addr_gen_c

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, width of one buffer address.
REQ-002 SHALL have parameter ARRAY_N, default 8, number of systolic-array output columns / buffer banks.
REQ-003 SHALL have parameter LEN_WIDTH, default 16, width of the per-lane row count.
REQ-004 SHALL have parameter CONCAT_ADDR_WIDTH, default ADDR_WIDTH*ARRAY_N.
REQ-005 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-006 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port start  input  1  one-cycle pulse that begins a tile write-back.
REQ-008 SHALL have port base_addr  input  ADDR_WIDTH  first buffer address of the tile, latched on accepted start.
REQ-009 SHALL have port length  input  LEN_WIDTH  writes expected per active lane, latched on accepted start.
REQ-010 SHALL have port num_cols  input  $clog2(ARRAY_N)+1  active columns, latched on accepted start.
REQ-011 SHALL have port in_valid  input  ARRAY_N  per-column result-valid from the array (skewed: column n lags column n-1 by one cycle).
REQ-012 SHALL have port wr_addr  output  CONCAT_ADDR_WIDTH  lane n write address at bits [ADDR_WIDTH*n +: ADDR_WIDTH].
REQ-013 SHALL have port wr_en  output  ARRAY_N  per-bank write enable.
REQ-014 SHALL have port busy  output  1  high while a tile is in progress (state RUN or DONE).
REQ-015 SHALL have port done  output  1  one-cycle completion pulse.
REQ-016 SHALL have port err_overflow  output  1  sticky flag: valid seen on an inactive or completed lane.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, DONE.
REQ-018 SHALL leave IDLE on start=1: to RUN if length!=0, else directly to DONE; base_addr, length, num_cols latched on that edge.
REQ-019 SHALL ignore start while in RUN or DONE (no re-latch, no counter clear).
REQ-020 SHALL clamp latched num_cols of 0 or >ARRAY_N to ARRAY_N.
REQ-021 SHALL keep one counter cnt[n] (LEN_WIDTH bits) per lane, cleared to 0 on accepted start.
REQ-022 SHALL accept a write on lane n in a cycle only when state=RUN, in_valid[n]=1, n<num_cols, cnt[n]<length.
REQ-023 SHALL, for an accepted write sampled in cycle t, drive wr_en[n]=1 and wr_addr lane n = base_addr + cnt[n] (value at t) in cycle t+1 (registered, latency 1), and increment cnt[n] at the same edge.
REQ-024 SHALL compute addresses modulo 2^ADDR_WIDTH (wrap, no saturation).
REQ-025 SHALL drive wr_en[n]=0 and hold wr_addr lane n at its last value in every cycle without an accepted write.
REQ-026 SHALL leave RUN for DONE in the cycle after all active lanes reach cnt[n]=length (i.e. done high one cycle after last wr_en).
REQ-027 SHALL assert done for exactly the one cycle spent in DONE, then return to IDLE.
REQ-028 SHALL set err_overflow when in_valid[n]=1 in RUN with n>=num_cols or cnt[n]=length; that valid produces no write.
REQ-029 SHALL clear err_overflow only on reset or accepted start; an overflow in the same cycle as start is ignored.
REQ-030 SHALL ignore in_valid in IDLE and DONE (no write, no error).
REQ-031 SHALL treat lanes independently; simultaneous valids on several lanes all write in the same cycle.

Reset
REQ-032 SHALL, on reset=1 at any edge (including mid-tile), force state IDLE, all cnt=0, wr_en=0, wr_addr=0, busy=0, done=0, err_overflow=0.
REQ-033 SHALL give reset priority over start in the same cycle.

Verification
REQ-034 Basic skew: ARRAY_N=8, base=0x100, length=4, num_cols=8, in_valid[n] high cycles n..n+3 after RUN -> lane n writes 0x100..0x103 one cycle later each; done once, one cycle after lane 7's last wr_en.
REQ-035 Partial columns: num_cols=3, valids driven on all 8 lanes -> writes only on lanes 0-2, err_overflow=1, done still asserted.
REQ-036 Wrap: base=0xFFFE, length=4 -> lane addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
REQ-037 Zero length: start with length=0 -> no wr_en, done high one cycle after start, busy high that cycle only.
REQ-038 Reset mid-tile: reset after 2 of 4 writes, then new start base=0x200 -> counters restart, first address 0x200, err_overflow=0.
REQ-039 Start while busy: second start during RUN with different base -> ignored, original addresses continue, single done.

Source files
------------

// File: rtl/write_addr_gen_c.sv
// Write-back address generator: turns skewed per-column result valids from a
// systolic array into per-bank write enables and sequential buffer addresses.
module write_addr_gen_c #(
    parameter int ADDR_WIDTH        = 16,
    parameter int ARRAY_N           = 8,
    parameter int LEN_WIDTH         = 16,
    parameter int CONCAT_ADDR_WIDTH = ADDR_WIDTH * ARRAY_N
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [ADDR_WIDTH-1:0]        base_addr,
    input  logic [LEN_WIDTH-1:0]         length,
    input  logic [$clog2(ARRAY_N):0]     num_cols,
    input  logic [ARRAY_N-1:0]           in_valid,
    output logic [CONCAT_ADDR_WIDTH-1:0] wr_addr,
    output logic [ARRAY_N-1:0]           wr_en,
    output logic                         busy,
    output logic                         done,
    output logic                         err_overflow
);

    localparam int unsigned NCW = $clog2(ARRAY_N) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                         state_q, state_d;
    logic [ADDR_WIDTH-1:0]          base_q, base_d;
    logic [LEN_WIDTH-1:0]           len_q, len_d;
    logic [NCW-1:0]                 ncols_q, ncols_d;
    logic [LEN_WIDTH-1:0]           cnt_q [ARRAY_N];
    logic [LEN_WIDTH-1:0]           cnt_d [ARRAY_N];
    logic [ARRAY_N-1:0]             wr_en_q, wr_en_d;
    logic [CONCAT_ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
    logic                           busy_q, busy_d;
    logic                           done_q, done_d;
    logic                           err_q, err_d;
    logic                           all_done;

    // Next-state, per-lane write acceptance and address computation
    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        len_d     = len_q;
        ncols_d   = ncols_q;
        cnt_d     = cnt_q;
        wr_en_d   = '0;
        wr_addr_d = wr_addr_q;
        err_d     = err_q;
        all_done  = 1'b1;

        case (state_q)
            IDLE: begin
                if (start) begin
                    base_d = base_addr;
                    len_d  = length;
                    // Zero or oversize column counts mean "use the full array"
                    if (num_cols == '0 || num_cols > NCW'(ARRAY_N)) begin
                        ncols_d = NCW'(ARRAY_N);
                    end else begin
                        ncols_d = num_cols;
                    end
                    for (int n = 0; n < ARRAY_N; n++) begin
                        cnt_d[n] = '0;
                    end
                    err_d   = 1'b0;
                    state_d = (length != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                for (int n = 0; n < ARRAY_N; n++) begin
                    // Completion is judged on counts before this cycle's writes,
                    // so done trails the final wr_en by one cycle.
                    if (NCW'(n) < ncols_q && cnt_q[n] != len_q) begin
                        all_done = 1'b0;
                    end
                    if (in_valid[n]) begin
                        if (NCW'(n) < ncols_q && cnt_q[n] < len_q) begin
                            wr_en_d[n] = 1'b1;
                            wr_addr_d[n*ADDR_WIDTH +: ADDR_WIDTH] =
                                base_q + ADDR_WIDTH'(cnt_q[n]);
                            cnt_d[n] = cnt_q[n] + LEN_WIDTH'(1);
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                if (all_done) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            base_q    <= '0;
            len_q     <= '0;
            ncols_q   <= '0;
            for (int n = 0; n < ARRAY_N; n++) begin
                cnt_q[n] <= '0;
            end
            wr_en_q   <= '0;
            wr_addr_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            len_q     <= len_d;
            ncols_q   <= ncols_d;
            for (int n = 0; n < ARRAY_N; n++) begin
                cnt_q[n] <= cnt_d[n];
            end
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign wr_addr      = wr_addr_q;
    assign wr_en        = wr_en_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err_overflow = err_q;

endmodule

// File: tb/tb_write_addr_gen_c.sv
// Self-checking bench for write_addr_gen_c: vector table, directed corner
// sequences, and random traffic against a lane-quota reference model.
module tb_write_addr_gen_c;

    logic         clk;
    logic         reset;
    logic         start;
    logic [15:0]  base_addr;
    logic [15:0]  length;
    logic [3:0]   num_cols;
    logic [7:0]   in_valid;
    logic [127:0] wr_addr;
    logic [7:0]   wr_en;
    logic         busy;
    logic         done;
    logic         err_overflow;

    write_addr_gen_c dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .base_addr    (base_addr),
        .length       (length),
        .num_cols     (num_cols),
        .in_valid     (in_valid),
        .wr_addr      (wr_addr),
        .wr_en        (wr_en),
        .busy         (busy),
        .done         (done),
        .err_overflow (err_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: each tile hands every active lane a quota of writes;
    // lane n's k-th write goes to base+k. Phase 0 idle, 1 running, 2 done.
    int          m_phase = 0;
    int unsigned m_base  = 0;
    int          m_sent  [8];
    int          m_quota [8];
    logic [7:0]  e_en    = '0;
    logic [15:0] e_addr  [8];
    logic        e_busy  = 1'b0;
    logic        e_done  = 1'b0;
    logic        e_err   = 1'b0;

    // Per-scenario observations
    int          cyc_no, done_cnt, wr_cnt, done_at, en7_at;
    logic [7:0]  en_or;
    logic [15:0] lane0_log [$];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, got, want, $time);
        end
    endtask

    task automatic model_step(input logic rst, input logic st, input logic [15:0] b,
                              input logic [15:0] l, input logic [3:0] nc, input logic [7:0] v);
        int eff;
        bit all_empty;
        if (rst) begin
            m_phase = 0;
            e_en    = '0;
            e_err   = 1'b0;
            for (int n = 0; n < 8; n++) begin
                e_addr[n]  = '0;
                m_sent[n]  = 0;
                m_quota[n] = 0;
            end
        end else begin
            e_en = '0;
            case (m_phase)
                0: if (st) begin
                    eff    = (nc == 0 || nc > 8) ? 8 : int'(nc);
                    m_base = int'(b);
                    for (int n = 0; n < 8; n++) begin
                        m_sent[n]  = 0;
                        m_quota[n] = (n < eff) ? int'(l) : 0;
                    end
                    e_err   = 1'b0;
                    m_phase = (l != 0) ? 1 : 2;
                end
                1: begin
                    all_empty = 1;
                    for (int n = 0; n < 8; n++)
                        if (m_sent[n] < m_quota[n]) all_empty = 0;
                    for (int n = 0; n < 8; n++) begin
                        if (v[n]) begin
                            if (m_sent[n] < m_quota[n]) begin
                                e_en[n]   = 1'b1;
                                e_addr[n] = 16'(m_base + 32'(m_sent[n]));
                                m_sent[n]++;
                            end else begin
                                e_err = 1'b1;
                            end
                        end
                    end
                    if (all_empty) m_phase = 2;
                end
                default: m_phase = 0;
            endcase
        end
        e_busy = (m_phase != 0);
        e_done = (m_phase == 2);
    endtask

    task automatic clr_stats();
        done_cnt = 0; wr_cnt = 0; done_at = -1; en7_at = -1; en_or = '0;
        lane0_log.delete();
    endtask

    // One clock: drive inputs, advance model and DUT, compare all outputs
    task automatic cyc(input logic rst, input logic st, input logic [15:0] b,
                       input logic [15:0] l, input logic [3:0] nc, input logic [7:0] v);
        reset = rst; start = st; base_addr = b; length = l; num_cols = nc; in_valid = v;
        model_step(rst, st, b, l, nc, v);
        @(posedge clk);
        #1;
        cyc_no++;
        chk("wr_en", 32'(wr_en), 32'(e_en));
        for (int n = 0; n < 8; n++)
            chk($sformatf("wr_addr[%0d]", n), 32'(wr_addr[16*n +: 16]), 32'(e_addr[n]));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("done", 32'(done), 32'(e_done));
        chk("err_overflow", 32'(err_overflow), 32'(e_err));
        if (done) begin done_cnt++; done_at = cyc_no; end
        if (wr_en[7]) en7_at = cyc_no;
        if (wr_en[0]) lane0_log.push_back(wr_addr[15:0]);
        wr_cnt += $countones(wr_en);
        en_or |= wr_en;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cyc(1'b0, 1'b0, 16'h0, 16'h0, 4'h0, 8'h00);
    endtask

    typedef struct {
        logic        rst, st;
        logic [15:0] base, len;
        logic [3:0]  nc;
        logic [7:0]  v;
        logic [7:0]  en;
        logic [15:0] a0, a7;
        logic        busy, done, err;
    } vec_t;

    vec_t tbl [14];

    initial begin
        cyc_no = 0;
        clr_stats();
        for (int n = 0; n < 8; n++) e_addr[n] = '0;

        // Hand-derived vectors: outputs expected after each row's clock edge
        tbl[0]  = '{1'b1, 1'b0, 16'h0000, 16'd0, 4'd0, 8'h00, 8'h00, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 16'h0010, 16'd2, 4'd1, 8'h00, 8'h00, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 16'h0000, 16'd0, 4'd0, 8'h01, 8'h01, 16'h0010, 16'h0000, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 16'h0000, 16'd0, 4'd0, 8'h01, 8'h01, 16'h0011, 16'h0000, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 16'h0000, 16'd0, 4'd0, 8'h00, 8'h00, 16'h0011, 16'h0000, 1'b1, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 16'h0000, 16'd0, 4'd0, 8'h00, 8'h00, 16'h0011, 16'h0000, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 16'h0050, 16'd0, 4'd0, 8'h00, 8'h00, 16'h0011, 16'h0000, 1'b1, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 16'h0000, 16'd0, 4'd0, 8'hFF, 8'h00, 16'h0011, 16'h0000, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 16'hFFFF, 16'd1, 4'd9, 8'h00, 8'h00, 16'h0011, 16'h0000, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 16'h0000, 16'd0, 4'd0, 8'h81, 8'h81, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 16'h0000, 16'd0, 4'd0, 8'h02, 8'h02, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 16'h0000, 16'd0, 4'd0, 8'h01, 8'h00, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b1};
        tbl[12] = '{1'b0, 1'b1, 16'h0000, 16'd5, 4'd2, 8'h00, 8'h00, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b1};
        tbl[13] = '{1'b1, 1'b0, 16'h0000, 16'd0, 4'd0, 8'h00, 8'h00, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0};

        for (int i = 0; i < 14; i++) begin
            cyc(tbl[i].rst, tbl[i].st, tbl[i].base, tbl[i].len, tbl[i].nc, tbl[i].v);
            chk($sformatf("tbl%0d.wr_en", i), 32'(wr_en), 32'(tbl[i].en));
            chk($sformatf("tbl%0d.addr0", i), 32'(wr_addr[15:0]), 32'(tbl[i].a0));
            chk($sformatf("tbl%0d.addr7", i), 32'(wr_addr[127:112]), 32'(tbl[i].a7));
            chk($sformatf("tbl%0d.busy", i), 32'(busy), 32'(tbl[i].busy));
            chk($sformatf("tbl%0d.done", i), 32'(done), 32'(tbl[i].done));
            chk($sformatf("tbl%0d.err", i), 32'(err_overflow), 32'(tbl[i].err));
        end

        // Basic skew across all eight columns
        clr_stats();
        cyc(1'b0, 1'b1, 16'h0100, 16'd4, 4'd8, 8'h00);
        for (int c = 0; c < 16; c++) begin
            logic [7:0] v;
            for (int n = 0; n < 8; n++) v[n] = (c >= n && c < n + 4);
            cyc(1'b0, 1'b0, 16'h0, 16'h0, 4'h0, v);
        end
        chk("skew.writes", 32'(wr_cnt), 32'd32);
        chk("skew.done_cnt", 32'(done_cnt), 32'd1);
        chk("skew.done_after_lane7", 32'(done_at), 32'(en7_at + 1));
        chk("skew.lane0_first", 32'(lane0_log[0]), 32'h0100);
        chk("skew.lane0_last", 32'(lane0_log[3]), 32'h0103);

        // Partial columns with valids on every lane
        clr_stats();
        cyc(1'b0, 1'b1, 16'h0040, 16'd2, 4'd3, 8'h00);
        cyc(1'b0, 1'b0, 16'h0, 16'h0, 4'h0, 8'hFF);
        cyc(1'b0, 1'b0, 16'h0, 16'h0, 4'h0, 8'hFF);
        idle(4);
        chk("partial.writes", 32'(wr_cnt), 32'd6);
        chk("partial.lanes", 32'(en_or), 32'h07);
        chk("partial.err", 32'(err_overflow), 32'd1);
        chk("partial.done_cnt", 32'(done_cnt), 32'd1);

        // Address wrap past the top of the buffer
        clr_stats();
        cyc(1'b0, 1'b1, 16'hFFFE, 16'd4, 4'd1, 8'h00);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 16'h0, 16'h0, 4'h0, 8'h01);
        idle(4);
        chk("wrap.count", 32'(lane0_log.size()), 32'd4);
        if (lane0_log.size() == 4) begin
            chk("wrap.a0", 32'(lane0_log[0]), 32'hFFFE);
            chk("wrap.a1", 32'(lane0_log[1]), 32'hFFFF);
            chk("wrap.a2", 32'(lane0_log[2]), 32'h0000);
            chk("wrap.a3", 32'(lane0_log[3]), 32'h0001);
        end

        // Zero-length tile
        clr_stats();
        cyc(1'b0, 1'b1, 16'h0077, 16'd0, 4'd8, 8'h00);
        chk("zero.busy", 32'(busy), 32'd1);
        chk("zero.done", 32'(done), 32'd1);
        cyc(1'b0, 1'b0, 16'h0, 16'h0, 4'h0, 8'hFF);
        chk("zero.busy_after", 32'(busy), 32'd0);
        chk("zero.done_after", 32'(done), 32'd0);
        chk("zero.writes", 32'(wr_cnt), 32'd0);

        // Reset in the middle of a tile, then a fresh tile
        cyc(1'b0, 1'b1, 16'h0100, 16'd4, 4'd1, 8'h00);
        cyc(1'b0, 1'b0, 16'h0, 16'h0, 4'h0, 8'h01);
        cyc(1'b0, 1'b0, 16'h0, 16'h0, 4'h0, 8'h01);
        cyc(1'b0, 1'b0, 16'h0, 16'h0, 4'h0, 8'h20);
        chk("rst.err_before", 32'(err_overflow), 32'd1);
        cyc(1'b1, 1'b1, 16'h0300, 16'd4, 4'd1, 8'h01);
        chk("rst.err", 32'(err_overflow), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.addr0", 32'(wr_addr[15:0]), 32'h0);
        clr_stats();
        cyc(1'b0, 1'b1, 16'h0200, 16'd4, 4'd1, 8'h00);
        cyc(1'b0, 1'b0, 16'h0, 16'h0, 4'h0, 8'h01);
        chk("rst.first_addr", 32'(wr_addr[15:0]), 32'h0200);
        chk("rst.err_new", 32'(err_overflow), 32'd0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 16'h0, 16'h0, 4'h0, 8'h01);
        idle(4);
        chk("rst.writes", 32'(wr_cnt), 32'd4);

        // Start while busy is ignored
        clr_stats();
        cyc(1'b0, 1'b1, 16'h0100, 16'd3, 4'd1, 8'h00);
        cyc(1'b0, 1'b0, 16'h0, 16'h0, 4'h0, 8'h01);
        cyc(1'b0, 1'b1, 16'h0300, 16'd3, 4'd1, 8'h01);
        cyc(1'b0, 1'b0, 16'h0, 16'h0, 4'h0, 8'h01);
        idle(5);
        chk("busy_start.count", 32'(lane0_log.size()), 32'd3);
        if (lane0_log.size() == 3) begin
            chk("busy_start.a0", 32'(lane0_log[0]), 32'h0100);
            chk("busy_start.a1", 32'(lane0_log[1]), 32'h0101);
            chk("busy_start.a2", 32'(lane0_log[2]), 32'h0102);
        end
        chk("busy_start.done_cnt", 32'(done_cnt), 32'd1);

        // Random traffic against the reference model
        for (int i = 0; i < 3000; i++) begin
            logic       r, s;
            logic [7:0] v;
            r = ($urandom_range(0, 199) == 0);
            s = ($urandom_range(0, 7) == 0);
            v = 8'($urandom) & 8'($urandom);
            cyc(r, s, 16'($urandom), 16'($urandom_range(0, 5)), 4'($urandom_range(0, 15)), v);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
